// File: rtl/ad9866_spi_ctrl.sv
// AD9866 serial-port controller: codec reset pulse, init-table replay, then runtime register frames.
// Optional read frames with sdo capture are built when AD9866_SPI_READBACK_EN is defined.
module ad9866_spi_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 64,
    parameter int GAP_CYCLES = 8,
    parameter int NUM_INIT   = 4,
    parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*14-1:0] INIT_TABLE = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic       wr_rw,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       ad9866_sclk,
    output logic       ad9866_sdio,
    input  logic       ad9866_sdo,
    output logic       ad9866_sen_n,
    output logic       ad9866_rst_n
);
    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        RST_WAIT  = 3'd1,
        INIT_LOAD = 3'd2,
        SHIFT     = 3'd3,
        GAP       = 3'd4,
        IDLE      = 3'd5
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  IDX_LAST = 8'((NUM_INIT > 0) ? NUM_INIT - 1 : 0);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_bit, w_bit_nxt;
    logic        r_phase, w_phase_nxt;
    logic [7:0]  r_idx, w_idx_nxt;
    logic [15:0] r_shift, w_shift_nxt;
    logic        r_sclk, w_sclk_nxt;
    logic        r_sen_n, w_sen_n_nxt;
    logic        r_crst_n, w_crst_n_nxt;
    logic        r_ack, w_ack_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [13:0] w_entry;
    logic [15:0] w_rt_frame;

    assign w_entry = INIT_TABLE[int'(r_idx)*14 +: 14];

`ifdef AD9866_SPI_READBACK_EN
    logic       r_is_rd, w_is_rd_nxt;
    logic [7:0] r_rx, w_rx_nxt;
    logic [7:0] r_rd_data, w_rd_data_nxt;
    logic       r_rd_valid, w_rd_valid_nxt;

    // Read frames carry a zero data field; the codec answers on sdo during bits 7:0.
    assign w_rt_frame = wr_rw ? {1'b1, 1'b0, wr_addr, 8'h00} : {1'b0, 1'b0, wr_addr, wr_data};
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
`else
    logic w_unused;

    assign w_unused   = wr_rw ^ ad9866_sdo;
    assign w_rt_frame = {1'b0, 1'b0, wr_addr, wr_data};
    assign rd_data    = 8'h00;
    assign rd_valid   = 1'b0;
`endif

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_phase_nxt  = r_phase;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_sclk_nxt   = r_sclk;
        w_sen_n_nxt  = r_sen_n;
        w_crst_n_nxt = r_crst_n;
        w_ack_nxt    = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
`ifdef AD9866_SPI_READBACK_EN
        w_is_rd_nxt    = r_is_rd;
        w_rx_nxt       = r_rx;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
`endif
        case (r_state)
            RST_HOLD: begin
                if (r_cnt == RST_LAST) begin
                    w_cnt_nxt    = 16'd0;
                    w_crst_n_nxt = 1'b1;
                    w_state_nxt  = RST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            RST_WAIT: begin
                if (r_cnt == RST_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (NUM_INIT == 0) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt   = 8'd0;
                        w_state_nxt = INIT_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            INIT_LOAD: begin
                w_shift_nxt = {2'b00, w_entry};
                w_cnt_nxt   = 16'd0;
                w_bit_nxt   = 4'd0;
                w_phase_nxt = 1'b0;
                w_sclk_nxt  = 1'b0;
                w_sen_n_nxt = 1'b0;
                w_state_nxt = SHIFT;
`ifdef AD9866_SPI_READBACK_EN
                w_is_rd_nxt = 1'b0;
`endif
            end
            SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_sclk_nxt  = 1'b1;
`ifdef AD9866_SPI_READBACK_EN
                        if (r_bit[3]) begin
                            w_rx_nxt = {r_rx[6:0], ad9866_sdo};
                        end else begin
                            w_rx_nxt = r_rx;
                        end
`endif
                    end else begin
                        // sdio only moves on the edge that drops sclk.
                        w_phase_nxt = 1'b0;
                        w_sclk_nxt  = 1'b0;
                        if (r_bit == 4'd15) begin
                            w_sen_n_nxt = 1'b1;
                            w_shift_nxt = 16'h0000;
                            w_state_nxt = GAP;
`ifdef AD9866_SPI_READBACK_EN
                            if (r_is_rd) begin
                                w_rd_data_nxt  = r_rx;
                                w_rd_valid_nxt = 1'b1;
                            end else begin
                                w_rd_data_nxt = r_rd_data;
                            end
`endif
                        end else begin
                            w_bit_nxt   = r_bit + 4'd1;
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_done && (r_idx != IDX_LAST)) begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = INIT_LOAD;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (wr_req) begin
                    w_ack_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_shift_nxt = w_rt_frame;
                    w_cnt_nxt   = 16'd0;
                    w_bit_nxt   = 4'd0;
                    w_phase_nxt = 1'b0;
                    w_sclk_nxt  = 1'b0;
                    w_sen_n_nxt = 1'b0;
                    w_state_nxt = SHIFT;
`ifdef AD9866_SPI_READBACK_EN
                    w_is_rd_nxt = wr_rw;
`endif
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = RST_HOLD;
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RST_HOLD;
            r_cnt    <= 16'd0;
            r_bit    <= 4'd0;
            r_phase  <= 1'b0;
            r_idx    <= 8'd0;
            r_shift  <= 16'h0000;
            r_sclk   <= 1'b0;
            r_sen_n  <= 1'b1;
            r_crst_n <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
`ifdef AD9866_SPI_READBACK_EN
            r_is_rd    <= 1'b0;
            r_rx       <= 8'h00;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_phase  <= w_phase_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_sclk   <= w_sclk_nxt;
            r_sen_n  <= w_sen_n_nxt;
            r_crst_n <= w_crst_n_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
`ifdef AD9866_SPI_READBACK_EN
            r_is_rd    <= w_is_rd_nxt;
            r_rx       <= w_rx_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
`endif
        end
    end

    assign wr_ack       = r_ack;
    assign busy         = r_busy;
    assign init_done    = r_done;
    assign ad9866_sclk  = r_sclk;
    assign ad9866_sdio  = r_shift[15];
    assign ad9866_sen_n = r_sen_n;
    assign ad9866_rst_n = r_crst_n;

endmodule

// File: doc/ad9866_spi_ctrl.md
Name: ad9866_spi_ctrl

Overview:
- Serial-port controller for the AD9866 codec; sits downstream of the core's configuration logic and drives the ad9866_sclk/sdio/sen_n/rst_n pins.
- After reset it pulses the codec reset and replays a parameterised init table.
- It then accepts runtime register writes (PGA, TX gain, filter) through a req/ack handshake.
- Runs on the ad9866spi clock domain; one clock only.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (≥1); sclk period = 2*CLK_DIV clks
RST_CYCLES, 64, clk cycles ad9866_rst_n held low, and also the wait after release
GAP_CYCLES, 8, clk cycles sen_n held high between frames (≥1)
NUM_INIT, 4, number of init-table entries (0 allowed: init skipped)
INIT_TABLE, {NUM_INIT x 14'h0}, packed {addr[5:0],data[7:0]}; entry 0 in LSBs, sent first

Ports:
clk  in  1  block clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  level request; hold until wr_ack
wr_rw  in  1  1=read frame (only honoured with macro)
wr_addr  in  6  register address
wr_data  in  8  write data
wr_ack  out  1  one-cycle pulse: request captured
busy  out  1  frame or init sequence in progress
init_done  out  1  sticky high once init table sent
rd_data  out  8  readback byte
rd_valid  out  1  one-cycle pulse: rd_data valid
ad9866_sclk  out  1  serial clock, idles low
ad9866_sdio  out  1  serial data out, MSB first
ad9866_sdo  in  1  serial data from codec
ad9866_sen_n  out  1  frame enable, active low
ad9866_rst_n  out  1  codec reset, active low

Behaviour:
- Reset values: sclk=0, sdio=0, sen_n=1, rst_n=0, wr_ack=0, busy=1, init_done=0, rd_data=0, rd_valid=0; state RST_HOLD.
- Reset asserted mid-frame aborts immediately to the reset values; the partial frame is discarded.
- States: RST_HOLD, RST_WAIT, INIT_LOAD, SHIFT, GAP, IDLE.
- RST_HOLD: rst_n=0 for RST_CYCLES clks -> RST_WAIT.
- RST_WAIT: rst_n=1, counted RST_CYCLES clks -> INIT_LOAD, or IDLE with init_done=1 when NUM_INIT=0.
- INIT_LOAD: load entry idx into the 16-bit shifter -> SHIFT.
- Frame format: bit15=R/W, bit14=0, bits13:8=addr, bits7:0=data; MSB first.
- SHIFT, half-period 0: sen_n=0 from the first SHIFT cycle; sdio presents the current bit; sclk=0 for CLK_DIV clks.
- SHIFT, half-period 1: sclk=1 for CLK_DIV clks. sdio changes only while sclk is low.
- After 16 sclk periods: sen_n=1, sclk=0 -> GAP.
- Frame length is exactly 32*CLK_DIV clks of sen_n low.
- GAP: GAP_CYCLES clks.
  - If init is unfinished: increment idx -> INIT_LOAD.
  - After the last entry: init_done=1 -> IDLE.
  - After a runtime frame: -> IDLE.
- IDLE: busy=0.
  - If wr_req=1: capture {rw,addr,data}, pulse wr_ack for 1 clk, set busy=1 in that same cycle, load the shifter -> SHIFT next clk.
- wr_req asserted during reset or init is held pending, not dropped, and is served at the first IDLE cycle.
- Back-to-back requests: at least GAP_CYCLES+1 clks from the end of one frame (sen_n rise) to the start of the next (sen_n fall).
- Address and data are taken only at the capture cycle; later changes on wr_addr/wr_data do not affect the frame in flight.

Optional Feature:
Macro AD9866_SPI_READBACK_EN.
- Defined:
  - When wr_rw=1, bit15=1 and the data field is sent as 0.
  - ad9866_sdo is sampled on each rising sclk during bits 7:0 and shifted MSB first.
  - At the transition into GAP: rd_data is updated and rd_valid pulses for 1 clk.
  - Write frames never pulse rd_valid and never change rd_data.
- Undefined: wr_rw is ignored (bit15 always 0); rd_data=0 and rd_valid=0 permanently; ad9866_sdo is unused.

Test Plan:
- Reset, NUM_INIT=0, RST_CYCLES=64 -> rst_n low for 64 clks, then high; init_done=1 and busy=0 exactly 64 clks later; sen_n never falls.
- IDLE, CLK_DIV=2, write addr=6'h0A data=8'h5C -> wr_ack one pulse; sen_n low exactly 64 clks; sampled bits 16'h0A5C; sclk 16 rising edges; sdio stable across every rising edge.
- NUM_INIT=2 with {6'h01,8'h11},{6'h02,8'h22}, plus wr_req held high from reset -> frames 16'h0111, 16'h0222, then the runtime frame, in that order; GAP_CYCLES between each; a single wr_ack.
- Assert rst_n=0 at sclk edge 7 of a runtime frame -> same cycle: sen_n=1, sclk=0, rst_n=0, busy=1; after release, the full reset/init sequence restarts.
- Change wr_data from 8'hAA to 8'h55 one clk after wr_ack -> the frame carries 8'hAA.
- With AD9866_SPI_READBACK_EN: read addr 6'h03, model drives sdo=8'hC3 -> frame bit15=1; rd_valid one pulse with rd_data=8'hC3. Without the macro, the same stimulus gives bit15=0 and rd_valid stays 0.
